// File: rtl/keypad_debounce_unit.sv
// Keypad line conditioner: synchronises each raw key line to CLK, debounces it on the
// tick_sample grid and derives clean levels, single-cycle press/release pulses, long-press
// flags and an encoded key event for the downstream power-state, gear and brake logic.
//
// Ports:
//   CLK              system clock
//   global_safe_rst  asynchronous, active-high reset
//   tick_sample      1-CLK debounce sample strobe
//   key_raw          raw key lines, active-high ([0..8]=1..9, [9]=*, [10]=0, [11]=#)
//   key_level        debounced level per key
//   key_press        1-CLK pulse on debounced 0->1
//   key_release      1-CLK pulse on debounced 1->0
//   key_hold         key has been pressed for at least HOLD_SAMPLES samples
//   key_code         lowest key index of the most recent press event (held between events)
//   key_valid        1-CLK pulse when any key_press bit is set
//   multi_press      1-CLK pulse when more than one key_press bit is set
module keypad_debounce_unit #(
  parameter int unsigned NKEYS        = 12,
  parameter int unsigned DEB_SAMPLES  = 4,
  parameter int unsigned HOLD_SAMPLES = 40
) (
  input  logic             CLK,
  input  logic             global_safe_rst,
  input  logic             tick_sample,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_hold,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             multi_press
);

  localparam int unsigned DebW  = $clog2(DEB_SAMPLES) + 1;
  localparam int unsigned HoldW = $clog2(HOLD_SAMPLES + 1);

  localparam logic [DebW-1:0]  DebLast = DebW'(DEB_SAMPLES - 1);
  localparam logic [DebW-1:0]  DebOne  = DebW'(1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_SAMPLES);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  logic [NKEYS-1:0] sync_meta_q;
  logic [NKEYS-1:0] sync_q;
  logic [NKEYS-1:0] level_q;
  logic [NKEYS-1:0] level_d;
  logic [NKEYS-1:0] level_dly_q;
  logic [DebW-1:0]  deb_cnt_q  [NKEYS];
  logic [DebW-1:0]  deb_cnt_d  [NKEYS];
  logic [HoldW-1:0] hold_cnt_q [NKEYS];
  logic [HoldW-1:0] hold_cnt_d [NKEYS];
  logic [3:0]       key_code_q;
  logic [3:0]       code_next;
  logic             multi;

  // Two-flop synchroniser, runs every cycle independent of the sample grid.
  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= key_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // Debounce: a level flips only after DEB_SAMPLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(NKEYS); i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (tick_sample) begin
        if (sync_q[i] == level_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          level_d[i]   = ~level_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebOne;
        end
      end
    end
  end

  // Hold counter: cleared whenever the level is low, saturates at HOLD_SAMPLES.
  always_comb begin
    for (int i = 0; i < int'(NKEYS); i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      if (!level_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (tick_sample && (hold_cnt_q[i] != HoldMax)) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HoldOne;
      end
    end
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < int'(NKEYS); i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      for (int i = 0; i < int'(NKEYS); i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  // Edge pulses and hold flags straight from registered state.
  always_comb begin
    key_level   = level_q;
    key_press   = level_q & ~level_dly_q;
    key_release = ~level_q & level_dly_q;
    for (int i = 0; i < int'(NKEYS); i++) begin
      key_hold[i] = (hold_cnt_q[i] == HoldMax);
    end
  end

  // Priority encoder: lowest pressed index wins; a second set bit flags a multi-press.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    multi     = 1'b0;
    code_next = key_code_q;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (key_press[i]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          code_next = 4'(i);
        end
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      key_code_q <= '0;
    end else if (key_valid) begin
      key_code_q <= code_next;
    end
  end

  always_comb begin
    key_valid   = |key_press;
    multi_press = key_valid & multi;
    key_code    = key_code_q;
  end

endmodule

// File: tb/tb_keypad_debounce_unit.sv
module tb_keypad_debounce_unit;

  localparam int NK  = 12;
  localparam int DEB = 4;

  logic          CLK;
  logic          global_safe_rst;
  logic          tick_sample;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_hold;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          multi_press;

  keypad_debounce_unit #(
    .NKEYS       (NK),
    .DEB_SAMPLES (DEB),
    .HOLD_SAMPLES(40)
  ) dut (
    .CLK            (CLK),
    .global_safe_rst(global_safe_rst),
    .tick_sample    (tick_sample),
    .key_raw        (key_raw),
    .key_level      (key_level),
    .key_press      (key_press),
    .key_release    (key_release),
    .key_hold       (key_hold),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .multi_press    (multi_press)
  );

  typedef struct {
    int            at;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lvl;
    logic [3:0]    code;
    logic          multi;
  } ev_t;

  ev_t           sb[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            ticks_on;
  logic [NK-1:0] exp_lvl;
  logic [3:0]    last_code;
  bit            code_due;
  logic [3:0]    due_code;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Tick lands on every posedge whose index is a multiple of 10.
  initial begin
    tick_sample = 1'b0;
    forever begin
      @(negedge CLK);
      tick_sample = ticks_on && (((cyc + 1) % 10) == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Posedge at which the debounced level flips for a raw change driven at the negedge of cyc c:
  // two sync stages, then the DEB-th tick that sees the new value.
  function automatic int flip_edge(input int c);
    int e;
    e = c + 3;
    while ((e % 10) != 0) e++;
    return e + 10 * (DEB - 1);
  endfunction

  task automatic push_ev(input int at, input logic [NK-1:0] pr, input logic [NK-1:0] rl);
    ev_t ev;
    exp_lvl = (exp_lvl | pr) & ~rl;
    if (pr != '0) begin
      for (int i = NK - 1; i >= 0; i--) if (pr[i]) last_code = 4'(i);
    end
    ev.at    = at;
    ev.pr    = pr;
    ev.rl    = rl;
    ev.lvl   = exp_lvl;
    ev.code  = last_code;
    ev.multi = ($countones(pr) > 1);
    sb.push_back(ev);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic align(input int ph);
    @(negedge CLK);
    while ((cyc % 10) != ph) @(negedge CLK);
  endtask

  // Event monitor: every visible pulse must match the head of the scoreboard.
  initial begin
    ev_t ev;
    code_due = 1'b0;
    forever begin
      @(negedge CLK);
      if (code_due) begin
        check_eq("code", key_code, due_code);
        code_due = 1'b0;
      end
      if ((key_press != '0) || (key_release != '0) || key_valid || multi_press) begin
        if (sb.size() == 0) begin
          check_eq("spurious", {key_press, key_release, key_valid, multi_press}, 0);
        end else begin
          ev = sb.pop_front();
          check_eq("ev_cyc", cyc, ev.at);
          check_eq("press", key_press, ev.pr);
          check_eq("release", key_release, ev.rl);
          check_eq("level", key_level, ev.lvl);
          check_eq("valid", key_valid, (ev.pr != '0));
          check_eq("multi", multi_press, ev.multi);
          code_due = 1'b1;
          due_code = ev.code;
        end
      end
    end
  end

  initial begin
    int c;
    int e;
    int r;
    logic [NK-1:0] saved_raw;

    global_safe_rst = 1'b1;
    key_raw         = '0;
    ticks_on        = 1'b1;
    exp_lvl         = '0;
    last_code       = '0;
    #1;
    check_eq("rst_level", key_level, 0);
    check_eq("rst_press", key_press, 0);
    check_eq("rst_hold", key_hold, 0);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_valid", {key_valid, multi_press}, 0);
    repeat (3) @(negedge CLK);
    align(2);
    global_safe_rst = 1'b0;

    // KEY_0 press and release.
    align(2);
    c = cyc;
    key_raw[10] = 1'b1;
    e = flip_edge(c);
    push_ev(e, 12'h400, 12'h000);
    wait_cyc(e - 1);
    check_eq("k0_pre_level", key_level[10], 0);
    wait_cyc(e + 2);
    align(2);
    c = cyc;
    key_raw[10] = 1'b0;
    push_ev(flip_edge(c), 12'h000, 12'h400);
    wait_cyc(flip_edge(c) + 2);

    // KEY_STAR bounce, one sample per value, then stable high.
    for (int i = 0; i < 5; i++) begin
      align(2);
      c = cyc;
      key_raw[9] = ((i % 2) == 0);
      check_eq("bounce_level", key_level[9], 0);
    end
    e = flip_edge(c);
    push_ev(e, 12'h200, 12'h000);
    wait_cyc(e + 2);
    align(2);
    c = cyc;
    key_raw[9] = 1'b0;
    push_ev(flip_edge(c), 12'h000, 12'h200);
    wait_cyc(flip_edge(c) + 2);

    // KEY_3 long press: hold after 40 further ticks, cleared one cycle after release.
    align(2);
    c = cyc;
    key_raw[2] = 1'b1;
    e = flip_edge(c);
    push_ev(e, 12'h004, 12'h000);
    wait_cyc(e + 399);
    check_eq("hold_early", key_hold, 0);
    wait_cyc(e + 400);
    check_eq("hold_set", key_hold, 12'h004);
    wait_cyc(e + 440);
    check_eq("hold_kept", key_hold, 12'h004);
    align(2);
    c = cyc;
    key_raw[2] = 1'b0;
    r = flip_edge(c);
    push_ev(r, 12'h000, 12'h004);
    wait_cyc(r);
    check_eq("hold_at_fall", key_hold, 12'h004);
    wait_cyc(r + 1);
    check_eq("hold_cleared", key_hold, 0);
    wait_cyc(r + 2);

    // KEY_8 and KEY_STAR together.
    align(2);
    c = cyc;
    key_raw[7] = 1'b1;
    key_raw[9] = 1'b1;
    e = flip_edge(c);
    push_ev(e, 12'h280, 12'h000);
    wait_cyc(e + 2);
    align(2);
    c = cyc;
    key_raw[7] = 1'b0;
    key_raw[9] = 1'b0;
    push_ev(flip_edge(c), 12'h000, 12'h280);
    wait_cyc(flip_edge(c) + 2);

    // KEY_9 held through a reset pulse re-qualifies from scratch.
    align(2);
    c = cyc;
    key_raw[8] = 1'b1;
    e = flip_edge(c);
    push_ev(e, 12'h100, 12'h000);
    wait_cyc(e + 2);
    align(5);
    global_safe_rst = 1'b1;
    exp_lvl   = '0;
    last_code = '0;
    #1;
    check_eq("mid_rst_level", key_level, 0);
    check_eq("mid_rst_code", key_code, 0);
    check_eq("mid_rst_pulses", {key_press, key_release, key_valid, multi_press}, 0);
    align(2);
    global_safe_rst = 1'b0;
    c = cyc;
    e = flip_edge(c);
    push_ev(e, 12'h100, 12'h000);
    wait_cyc(e + 2);

    // Sampling stopped: raw noise must not move anything.
    align(2);
    ticks_on  = 1'b0;
    saved_raw = key_raw;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      key_raw = NK'($urandom);
    end
    align(2);
    key_raw = saved_raw;
    check_eq("frozen_level", key_level, exp_lvl);
    align(2);
    ticks_on = 1'b1;
    wait_cyc(cyc + 35);
    check_eq("resume_level", key_level, exp_lvl);

    // Three-sample pulse on KEY_1 is rejected.
    align(2);
    c = cyc;
    key_raw[0] = 1'b1;
    wait_cyc(c + 30);
    key_raw[0] = 1'b0;
    wait_cyc(c + 80);
    check_eq("short_pulse_level", key_level, exp_lvl);

    align(2);
    c = cyc;
    key_raw[8] = 1'b0;
    push_ev(flip_edge(c), 12'h000, 12'h100);
    wait_cyc(flip_edge(c) + 5);

    check_eq("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
